spi_slave_cs: RTL
=================

Name: spi_slave_cs

Overview:
SPI responder (target) with chip-select framing. It is the counterpart of the team's SPI master with CS. SPI_Clk, SPI_CS_n and SPI_MOSI are synchronised into the system_clk domain and the block shifts bytes MSB-first in both directions. It exposes a one-byte TX holding buffer with a valid/ready handshake, a per-byte RX_valid strobe and a per-frame byte count.

Parameters:
SPI_MODE, 0, SPI mode 0-3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
MAX_BYTES_PER_CS, 2, saturation limit of o_RX_Count (count width CW = $clog2(MAX_BYTES_PER_CS+1))
IDLE_TX_BYTE, 8'hFF, byte shifted out on TX underrun

Ports:
system_clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
TX_Byte  in  8  next byte to send
TX_valid  in  1  TX_Byte valid; accepted when TX_valid & TX_ready
TX_ready  out  1  TX holding buffer empty
o_TX_underrun  out  1  1-cycle pulse: byte start with empty buffer
RX_Byte  out  8  last complete received byte
RX_valid  out  1  1-cycle pulse, RX_Byte updated
o_RX_Count  out  CW  complete bytes in current/last frame, saturating
o_CS_active  out  1  synchronised, active-high chip select
SPI_Clk  in  1  SCK from master
SPI_CS_n  in  1  chip select, active low
SPI_MOSI  in  1  master-out data
SPI_MISO  out  1  slave-out data
SPI_MISO_oe  out  1  MISO output enable (tristate at top level)

Behaviour:
- Reset (async, active low) values: TX_ready=1, buffer empty, RX_Byte=0, RX_valid=0, o_TX_underrun=0, o_RX_Count=0, o_CS_active=0, SPI_MISO=0, SPI_MISO_oe=0. Synchronisers reset to their idle levels: SCK=CPOL, CS_n=1.
- Synchronisation: 2-FF synchroniser on SCK, CS_n and MOSI, plus one extra registered SCK stage for edge detection.
- Supported SCK rate: SCK half-period >= 4 system_clk cycles.
- Edge definitions:
  - Leading edge = SCK leaves CPOL level; trailing edge = SCK returns to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Drive edge = the other edge.
- FSM states:
  - IDLE: CS inactive. On a synchronised CS falling edge, go to ACTIVE. Same cycle: o_RX_Count<=0, bit_cnt<=0, and o_CS_active is 1 from the next cycle.
  - ACTIVE: bits are shifted. On a synchronised CS rising edge, go to IDLE.
- Any CS rising edge (including mid-byte) returns to IDLE. A partial byte is discarded: no RX_valid, bit_cnt cleared, o_RX_Count held until the next CS fall.
- SCK edges are ignored in IDLE.
- RX path:
  - On each sample edge: rx_shift <= {rx_shift[6:0], MOSI_sync}, bit_cnt++ (3-bit, wraps 7->0).
  - On the 8th sample edge: RX_Byte <= completed byte and RX_valid=1 for exactly one cycle, registered one cycle after the edge is detected. o_RX_Count increments, saturating at MAX_BYTES_PER_CS.
  - RX has no backpressure.
- TX path: tx_shift is loaded at a byte-start event.
  - CPHA=0 byte-start events: CS fall detect; and the trailing edge following the 8th sample edge, while CS is still active.
  - CPHA=1 byte-start event: the leading edge with bit_cnt==0.
  - Load source: the holding buffer if full (buffer then empties, TX_ready=1 next cycle). Otherwise load IDLE_TX_BYTE and pulse o_TX_underrun.
  - Other drive edges: tx_shift shifts left.
  - SPI_MISO = tx_shift[7] while in ACTIVE, else 0. SPI_MISO_oe = (state==ACTIVE).
- TX handshake:
  - Buffer write occurs on TX_valid & TX_ready.
  - TX_valid while TX_ready=0 is ignored; TX_Byte need not be held.
  - A write in the same cycle as a byte-start event with an empty buffer does not bypass: it is an underrun, and the new byte is stored for the following byte.
  - The buffer persists across frames.
- Reset mid-frame: all state returns to reset values immediately. After reset release the block waits for a fresh CS falling edge; if CS_n is already low at release, that frame is ignored.

Test Plan:
- Mode 0, buffer preloaded 8'h96, 8'h5A written on TX_ready, master sends 8'hA5, 8'h3C in one CS frame -> RX_valid twice with RX_Byte A5 then 3C; master sees MISO 96, 5A; o_RX_Count=2; no underrun.
- Mode 3, single byte, MOSI 8'hC3, buffer 8'h81 -> RX_Byte=C3, MISO=81, o_RX_Count=1, MISO_oe low after CS rises.
- Mode 1, two bytes with only one byte buffered (8'h11) -> MISO 11, FF; o_TX_underrun pulses once at the second byte start.
- Mode 2, CS raised after 5 SCK periods -> no RX_valid, o_RX_Count=0; next full frame receives 8'h7E correctly.
- Mode 0, 3 bytes in one frame with MAX_BYTES_PER_CS=2 -> RX_valid x3, o_RX_Count saturates at 2; cleared to 0 at the next CS fall.
- Reset asserted mid-byte -> all outputs at reset values, TX_ready=1; a subsequent frame with 8'h55 is received cleanly.

Source files
------------

// File: rtl/spi_slave_cs.sv
// SPI responder with chip-select framing: synchronises SCK/CS_n/MOSI into system_clk,
// shifts bytes MSB-first both ways, one-byte TX holding buffer, per-byte RX strobe, frame byte count.
module spi_slave_cs #(
    parameter int unsigned  SPI_MODE         = 0,
    parameter int unsigned  MAX_BYTES_PER_CS = 2,
    parameter logic [7:0]   IDLE_TX_BYTE     = 8'hFF,
    localparam int unsigned CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          system_clk,
    input  logic          reset,
    input  logic [7:0]    TX_Byte,
    input  logic          TX_valid,
    output logic          TX_ready,
    output logic          o_TX_underrun,
    output logic [7:0]    RX_Byte,
    output logic          RX_valid,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_CS_active,
    input  logic          SPI_Clk,
    input  logic          SPI_CS_n,
    input  logic          SPI_MOSI,
    output logic          SPI_MISO,
    output logic          SPI_MISO_oe
);

    localparam logic CPOL = SPI_MODE[1];
    localparam logic CPHA = SPI_MODE[0];

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic       sck_meta, sck_sync, sck_prev;
    logic       cs_meta, cs_sync, cs_prev;
    logic       mosi_meta, mosi_sync;
    logic [1:0] sync_fill;
    logic       armed;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [6:0]    rx_shift, rx_shift_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic [7:0]    buf_data, buf_data_n;
    logic          tx_ready_n;
    logic [7:0]    rx_byte_n;
    logic          rx_valid_n;
    logic          underrun_n;
    logic [CW-1:0] count_n;
    logic          byte_start;

    logic lead_edge, trail_edge, sample_edge, drive_edge;
    logic cs_fall, cs_rise, buf_write;

    // Input synchronisers; armed blocks a frame already in progress when reset is released
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            sck_meta  <= CPOL;
            sck_sync  <= CPOL;
            sck_prev  <= CPOL;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sck_meta  <= SPI_Clk;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            cs_meta   <= SPI_CS_n;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            mosi_meta <= SPI_MOSI;
            mosi_sync <= mosi_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & cs_sync);
        end
    end

    assign lead_edge   = (sck_sync != CPOL) && (sck_prev == CPOL);
    assign trail_edge  = (sck_sync == CPOL) && (sck_prev != CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = armed & cs_prev & ~cs_sync;
    assign cs_rise     = ~cs_prev & cs_sync;
    assign buf_write   = TX_valid & TX_ready;

    // Next-state and datapath update
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        rx_shift_n = rx_shift;
        tx_shift_n = tx_shift;
        buf_data_n = buf_data;
        tx_ready_n = TX_ready;
        rx_byte_n  = RX_Byte;
        rx_valid_n = 1'b0;
        underrun_n = 1'b0;
        count_n    = o_RX_Count;
        byte_start = 1'b0;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n    = ACTIVE;
                    count_n    = '0;
                    bit_cnt_n  = 3'd0;
                    byte_start = ~CPHA;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_n   = IDLE;
                    bit_cnt_n = 3'd0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_n = {rx_shift[5:0], mosi_sync};
                        bit_cnt_n  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_byte_n  = {rx_shift, mosi_sync};
                            rx_valid_n = 1'b1;
                            if (o_RX_Count != CW'(MAX_BYTES_PER_CS)) begin
                                count_n = o_RX_Count + CW'(1);
                            end
                        end
                    end
                    // bit_cnt is 0 on a drive edge only before a byte's first sample
                    if (drive_edge) begin
                        if (bit_cnt == 3'd0) begin
                            byte_start = 1'b1;
                        end else begin
                            tx_shift_n = {tx_shift[6:0], 1'b0};
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (buf_write) begin
            buf_data_n = TX_Byte;
            tx_ready_n = 1'b0;
        end

        // A write landing with an empty buffer at byte start is kept for the next byte
        if (byte_start) begin
            if (!TX_ready) begin
                tx_shift_n = buf_data;
                tx_ready_n = 1'b1;
            end else begin
                tx_shift_n = IDLE_TX_BYTE;
                underrun_n = 1'b1;
            end
        end
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            rx_shift      <= 7'd0;
            tx_shift      <= 8'd0;
            buf_data      <= 8'd0;
            TX_ready      <= 1'b1;
            RX_Byte       <= 8'd0;
            RX_valid      <= 1'b0;
            o_TX_underrun <= 1'b0;
            o_RX_Count    <= '0;
            o_CS_active   <= 1'b0;
            SPI_MISO      <= 1'b0;
            SPI_MISO_oe   <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            rx_shift      <= rx_shift_n;
            tx_shift      <= tx_shift_n;
            buf_data      <= buf_data_n;
            TX_ready      <= tx_ready_n;
            RX_Byte       <= rx_byte_n;
            RX_valid      <= rx_valid_n;
            o_TX_underrun <= underrun_n;
            o_RX_Count    <= count_n;
            o_CS_active   <= (state_n == ACTIVE);
            SPI_MISO      <= (state_n == ACTIVE) & tx_shift_n[7];
            SPI_MISO_oe   <= (state_n == ACTIVE);
        end
    end

endmodule
